mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the 16-bit CPU. It sequences one shared memory port, one ALU and the register file over several clock cycles per instruction, replacing the single-cycle combinational control path. It decodes the 3-bit `op` and 4-bit `funct` fields latched in the instruction register, waits on a ready/request memory handshake, and aborts stalled memory accesses with a watchdog counter.

## Interface
Parameters:
- `N`, 16, datapath width. Carried for consistency with the datapath; it does not change control behaviour.
- `WAIT_LIMIT`, 15, maximum consecutive cycles spent waiting on `mem_ready` before abort. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  3  opcode from the instruction register.
- `funct`  in  4  function field from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current request this cycle.
- `memreq`  out  1  memory access request.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  destination register: 1 = rd, 0 = rt.
- `memtoreg`  out  1  register write data: 1 = MDR, 0 = ALUOut.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B input: 00 = B, 01 = constant 2, 10 = sign-extended immediate, 11 = immediate << 1.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC write enable.
- `alucontrol`  out  3  ALU operation.
- `illegal`  out  1  one-cycle pulse on an undefined opcode or funct.
- `mem_timeout`  out  1  one-cycle pulse when a memory wait aborts.

## Operation
Opcodes:
- 000 R-type
- 001 addi
- 100 lw
- 101 sw
- 110 beq
- 111 j
- 010 and 011 are illegal.

R-type funct to `alucontrol`:
- 0001 add → 010
- 0011 sub → 110
- 0100 and → 000
- 0101 or → 001
- 1010 slt → 111
- Any other funct is illegal.

States (Moore outputs). Signals not listed are 0; `alucontrol` defaults to 010 (add).
- FETCH: `memreq`, `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00. `irwrite` and `pcen` assert only while `mem_ready`=1. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11 (branch target). Next state: 000 → EXECUTE; 001 → ADDIEX; 100/101 → MEMADR; 110 → BRANCH; 111 → JUMP; illegal → FETCH with `illegal`=1.
- MEMADR: `alusrca`=1, `alusrcb`=10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `memreq`, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite`, `memtoreg`=1, `regdst`=0. Next state FETCH.
- MEMWR: `memreq`, `memwrite`, `iord`=1, held until `mem_ready`. Next state FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `alucontrol` from funct. An illegal funct goes to FETCH with `illegal`=1; otherwise the next state is ALUWB.
- ALUWB: `regwrite`, `regdst`=1. Next state FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10. Next state ADDIWB.
- ADDIWB: `regwrite`, `regdst`=0. Next state FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `alucontrol`=110, `pcsrc`=01, `pcen`=`zero`. Next state FETCH.
- JUMP: `pcsrc`=10, `pcen`=1. Next state FETCH.

Watchdog:
- An 8-bit wait counter increments each cycle spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
- It clears on every state change.
- When the counter equals `WAIT_LIMIT` and `mem_ready`=0:
  - `mem_timeout` pulses for that cycle.
  - `memwrite`, `irwrite`, `pcen` and `regwrite` are 0 for that cycle.
  - The next state is FETCH, which retries from the unchanged PC.
- If `mem_ready`=1 arrives in the same cycle as the limit, `mem_ready` wins: the access completes normally and there is no timeout.

## Timing
- Reset: while `reset`=1, every output is forced to 0 combinationally, including `alucontrol`=000. On the first edge with `reset`=1, the state becomes FETCH and the counter becomes 0.
- Reset asserted mid-instruction abandons the instruction. No write enable asserts in any cycle where `reset`=1.
- Cycles per instruction with zero-wait memory: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle in FETCH, MEMRD or MEMWR adds one.
- All outputs are combinational from state plus `mem_ready`, `zero`, `op`, `funct` and `reset`. There are no registered outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - the `state_t` enum;
  - opcode and funct localparams;
  - `alucontrol`, `alusrcb` and `pcsrc` encodings.
- Sub-module `aludec` is a combinational funct-to-`alucontrol` decoder with a valid output. The remainder (state register, next-state logic, output decode, watchdog counter) lives in `mc_controller`.

## Test plan
- **R-type add.** Stimulus: reset 2 cycles, `op`=000, `funct`=0001, `mem_ready`=1. Required: state sequence FETCH, DECODE, EXECUTE, ALUWB, FETCH; `alucontrol`=010 in EXECUTE; `regwrite`=1 and `regdst`=1 only in ALUWB.
- **lw with 3 wait cycles in MEMRD.** Required: `memreq`=1 and `iord`=1 held for 4 cycles; MEMWB follows; `regwrite`=1 and `memtoreg`=1 there; 8 cycles total.
- **beq.** With `zero`=1: `pcen`=1 and `pcsrc`=01 in BRANCH. With `zero`=0: `pcen`=0. Both return to FETCH after 3 cycles.
- **Illegal inputs.** `op`=010: `illegal` pulses in DECODE and the next state is FETCH. `op`=000, `funct`=1111: `illegal` pulses in EXECUTE and `regwrite` never asserts.
- **Watchdog.** Stimulus: `WAIT_LIMIT`=3, `mem_ready`=0 in MEMWR. Required: `mem_timeout` pulses on the 4th MEMWR cycle with `memwrite`=0 that cycle, then the state is FETCH. A repeat run with `mem_ready` rising exactly in that cycle completes the write with no timeout.
- **Reset mid-instruction.** Stimulus: `reset` asserted during ALUWB. Required: `regwrite`=0 that cycle; state is FETCH after the edge; all outputs are 0 while `reset` is high.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle CPU control path.
// Contents:
//   state_t        - controller FSM states
//   OP_*           - 3-bit opcode values
//   FUNCT_*        - 4-bit R-type function values
//   ALU_*          - alucontrol encodings
//   SRCB_*         - alusrcb encodings
//   PCSRC_*        - pcsrc encodings
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_ADDIEX,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_J     = 3'b111;

  localparam logic [3:0] FUNCT_ADD = 4'b0001;
  localparam logic [3:0] FUNCT_SUB = 4'b0011;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type function decoder: maps the 4-bit funct field to an ALU operation.
// Ports:
//   funct      in  4  function field of the current instruction
//   alucontrol out 3  ALU operation (add when funct is undefined)
//   valid      out 1  funct is one of the defined R-type operations
module aludec
  import cpu_pkg::*;
(
  input  logic [3:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default:   valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the 16-bit CPU. Sequences the shared memory
// port, ALU and register file over several cycles per instruction, with a
// ready/request memory handshake and a watchdog that aborts stalled accesses.
// All outputs are combinational from state, mem_ready, zero, op, funct, reset.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   op, funct, zero        instruction fields and ALU zero flag
//   mem_ready              memory completed the current request this cycle
//   memreq/iord/memwrite   memory request, address select, write
//   irwrite, pcen, pcsrc   instruction register load, PC write and source
//   regdst/memtoreg/regwrite  register file controls
//   alusrca/alusrcb/alucontrol  ALU operand selects and operation
//   illegal, mem_timeout   single-cycle event pulses
module mc_controller
  import cpu_pkg::*;
#(
  parameter int N          = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memreq,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       mem_timeout
);

  if (N < 1 || WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_param_check
    $error("mc_controller: N must be >= 1 and WAIT_LIMIT in 1..255");
  end

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] dec_alu;
  logic       dec_valid;
  logic       mem_wait;
  logic       timeout;

  aludec u_aludec (
    .funct      (funct),
    .alucontrol (dec_alu),
    .valid      (dec_valid)
  );

  // A cycle counts as a memory wait only in the three handshake states.
  always_comb begin
    mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
               && !mem_ready;
    timeout  = mem_wait && (wait_cnt_q == LIMIT);
  end

  always_comb begin
    state_d     = state_q;
    memreq      = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    pcsrc       = PCSRC_ALU;
    pcen        = 1'b0;
    alucontrol  = ALU_ADD;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      S_FETCH: begin
        memreq  = 1'b1;
        alusrcb = SRCB_TWO;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH;
        case (op)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = dec_alu;
        if (!dec_valid) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = zero;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Abort a stalled access; the PC was never advanced, so FETCH retries it.
    if (timeout) begin
      mem_timeout = 1'b1;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      pcen        = 1'b0;
      regwrite    = 1'b0;
      state_d     = S_FETCH;
    end

    if (reset) begin
      memreq      = 1'b0;
      iord        = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      pcen        = 1'b0;
      alucontrol  = 3'b000;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      state_d     = S_FETCH;
    end
  end

  // A FETCH timeout stays in FETCH, so clear on timeout as well as on a
  // state change to give the retry a full wait window.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (reset || timeout || (state_d != state_q)) begin
      wait_cnt_d = 8'd0;
    end else if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller (WAIT_LIMIT = 3). Outputs are packed
// into one vector and compared per cycle against hand-written state patterns.
// Vector layout: memreq iord memwrite irwrite regdst memtoreg regwrite alusrca
//                alusrcb[1:0] pcsrc[1:0] pcen alucontrol[2:0] illegal mem_timeout
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal, mem_timeout;
  logic [17:0] outv;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mc_controller #(.N(16), .WAIT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memreq(memreq), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  assign outv = {memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal, mem_timeout};

  localparam logic [17:0] E_ZERO    = 18'b0;
  localparam logic [17:0] E_F_RDY   = 18'b1_0_0_1_0_0_0_0_01_00_1_010_0_0;
  localparam logic [17:0] E_F_WAIT  = 18'b1_0_0_0_0_0_0_0_01_00_0_010_0_0;
  localparam logic [17:0] E_F_TO    = 18'b1_0_0_0_0_0_0_0_01_00_0_010_0_1;
  localparam logic [17:0] E_DEC     = 18'b0_0_0_0_0_0_0_0_11_00_0_010_0_0;
  localparam logic [17:0] E_DEC_ILL = 18'b0_0_0_0_0_0_0_0_11_00_0_010_1_0;
  localparam logic [17:0] E_EX_ADD  = 18'b0_0_0_0_0_0_0_1_00_00_0_010_0_0;
  localparam logic [17:0] E_EX_SUB  = 18'b0_0_0_0_0_0_0_1_00_00_0_110_0_0;
  localparam logic [17:0] E_EX_AND  = 18'b0_0_0_0_0_0_0_1_00_00_0_000_0_0;
  localparam logic [17:0] E_EX_OR   = 18'b0_0_0_0_0_0_0_1_00_00_0_001_0_0;
  localparam logic [17:0] E_EX_SLT  = 18'b0_0_0_0_0_0_0_1_00_00_0_111_0_0;
  localparam logic [17:0] E_ALUWB   = 18'b0_0_0_0_1_0_1_0_00_00_0_010_0_0;
  localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_1_10_00_0_010_0_0;
  localparam logic [17:0] E_MEMRD   = 18'b1_1_0_0_0_0_0_0_00_00_0_010_0_0;
  localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_1_1_0_00_00_0_010_0_0;
  localparam logic [17:0] E_MEMWR   = 18'b1_1_1_0_0_0_0_0_00_00_0_010_0_0;
  localparam logic [17:0] E_MEMWR_TO= 18'b1_1_0_0_0_0_0_0_00_00_0_010_0_1;
  localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_1_0_00_00_0_010_0_0;
  localparam logic [17:0] E_BR_T    = 18'b0_0_0_0_0_0_0_1_00_01_1_110_0_0;
  localparam logic [17:0] E_BR_NT   = 18'b0_0_0_0_0_0_0_1_00_01_0_110_0_0;
  localparam logic [17:0] E_JUMP    = 18'b0_0_0_0_0_0_0_0_00_10_1_010_0_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = 3'b000; funct = 4'b0001; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (outv !== E_ZERO) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, outv, E_ZERO);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (outv !== E_F_RDY) begin
      tests_failed++;
      $display("FAIL reset_release got=%b exp=%b", outv, E_F_RDY);
    end
    $display("[TB] reset checked");
  endtask

  // R-type: 4 cycles per instruction, one instruction per defined funct.
  task automatic test_rtype();
    logic [3:0]  fn [5]  = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1010};
    logic [17:0] ex [5]  = '{E_EX_ADD, E_EX_SUB, E_EX_AND, E_EX_OR, E_EX_SLT};
    logic [17:0] seq [5];
    for (int k = 0; k < 5; k++) begin
      op = 3'b000; funct = fn[k]; mem_ready = 1'b1;
      seq = '{E_F_RDY, E_DEC, ex[k], E_ALUWB, E_F_RDY};
      for (int i = 0; i < 5; i++) begin
        #1;
        tests_run++;
        if (outv !== seq[i]) begin
          tests_failed++;
          $display("FAIL rtype funct=%b cyc%0d got=%b exp=%b", fn[k], i, outv, seq[i]);
        end
        if (i < 4) tick();
      end
      $display("[TB] rtype funct=%b done", fn[k]);
    end
  endtask

  task automatic test_addi_jump();
    logic [17:0] sa [5] = '{E_F_RDY, E_DEC, E_MEMADR, E_ADDIWB, E_F_RDY};
    logic [17:0] sj [4] = '{E_F_RDY, E_DEC, E_JUMP, E_F_RDY};
    op = 3'b001; funct = 4'b0000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (outv !== sa[i]) begin
        tests_failed++;
        $display("FAIL addi cyc%0d got=%b exp=%b", i, outv, sa[i]);
      end
      if (i < 4) tick();
    end
    $display("[TB] addi done");
    op = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (outv !== sj[i]) begin
        tests_failed++;
        $display("FAIL jump cyc%0d got=%b exp=%b", i, outv, sj[i]);
      end
      if (i < 3) tick();
    end
    $display("[TB] jump done");
  endtask

  // lw with 3 wait cycles in MEMRD: 8 cycles total.
  task automatic test_lw_wait();
    logic [17:0] seq [9] = '{E_F_RDY, E_DEC, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD,
                             E_MEMRD, E_MEMWB, E_F_RDY};
    bit          rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 3'b100; funct = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      #1;
      tests_run++;
      if (outv !== seq[i]) begin
        tests_failed++;
        $display("FAIL lw_wait cyc%0d got=%b exp=%b", i, outv, seq[i]);
      end
      if (i < 8) tick();
    end
    $display("[TB] lw with 3 waits done");
  endtask

  task automatic test_sw();
    logic [17:0] seq [5] = '{E_F_RDY, E_DEC, E_MEMADR, E_MEMWR, E_F_RDY};
    op = 3'b101; funct = 4'b0000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (outv !== seq[i]) begin
        tests_failed++;
        $display("FAIL sw cyc%0d got=%b exp=%b", i, outv, seq[i]);
      end
      if (i < 4) tick();
    end
    $display("[TB] sw done");
  endtask

  task automatic test_beq();
    logic [17:0] seq [4];
    op = 3'b110; funct = 4'b0000; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      seq = '{E_F_RDY, E_DEC, (z == 1) ? E_BR_T : E_BR_NT, E_F_RDY};
      for (int i = 0; i < 4; i++) begin
        #1;
        tests_run++;
        if (outv !== seq[i]) begin
          tests_failed++;
          $display("FAIL beq zero=%0d cyc%0d got=%b exp=%b", z, i, outv, seq[i]);
        end
        if (i < 3) tick();
      end
      $display("[TB] beq zero=%0d done", z);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0]  ops [2] = '{3'b010, 3'b011};
    logic [17:0] seq [3] = '{E_F_RDY, E_DEC_ILL, E_F_RDY};
    mem_ready = 1'b1; funct = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 3; i++) begin
        #1;
        tests_run++;
        if (outv !== seq[i]) begin
          tests_failed++;
          $display("FAIL illegal_op op=%b cyc%0d got=%b exp=%b", ops[k], i, outv, seq[i]);
        end
        if (i < 2) tick();
      end
      $display("[TB] illegal op=%b done", ops[k]);
    end
    // Undefined funct: illegal pulses in EXECUTE, then straight back to FETCH.
    op = 3'b000; funct = 4'b1111;
    tick(); #1;
    tests_run++;
    if (outv !== E_DEC) begin
      tests_failed++;
      $display("FAIL illegal_funct_decode got=%b exp=%b", outv, E_DEC);
    end
    tick(); #1;
    tests_run++;
    if ({illegal, regwrite, alusrca, memreq} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL illegal_funct_exec got(ill,rw,srca,mreq)=%b exp=1010",
               {illegal, regwrite, alusrca, memreq});
    end
    tick(); #1;
    tests_run++;
    if (outv !== E_F_RDY) begin
      tests_failed++;
      $display("FAIL illegal_funct_return got=%b exp=%b", outv, E_F_RDY);
    end
    $display("[TB] illegal funct done");
  endtask

  // WAIT_LIMIT=3: the 4th waiting MEMWR cycle aborts; a retry where mem_ready
  // rises in that same cycle completes normally.
  task automatic test_watchdog();
    logic [17:0] s_to [8] = '{E_F_RDY, E_DEC, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR,
                              E_MEMWR_TO, E_F_RDY};
    logic [17:0] s_ok [8] = '{E_F_RDY, E_DEC, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR,
                              E_MEMWR, E_F_RDY};
    bit          r_to [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bit          r_ok [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] s_f  [6] = '{E_F_WAIT, E_F_WAIT, E_F_WAIT, E_F_TO, E_F_WAIT, E_F_RDY};
    bit          r_f  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 3'b101; funct = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r_to[i];
      #1;
      tests_run++;
      if (outv !== s_to[i]) begin
        tests_failed++;
        $display("FAIL watchdog_abort cyc%0d got=%b exp=%b", i, outv, s_to[i]);
      end
      if (i < 7) tick();
    end
    $display("[TB] watchdog abort done");
    for (int i = 0; i < 8; i++) begin
      mem_ready = r_ok[i];
      #1;
      tests_run++;
      if (outv !== s_ok[i]) begin
        tests_failed++;
        $display("FAIL watchdog_ready_wins cyc%0d got=%b exp=%b", i, outv, s_ok[i]);
      end
      if (i < 7) tick();
    end
    $display("[TB] watchdog ready-at-limit done");
    // Stalled fetch: abort on 4th wait, counter restarts for the retry.
    for (int i = 0; i < 6; i++) begin
      mem_ready = r_f[i];
      #1;
      tests_run++;
      if (outv !== s_f[i]) begin
        tests_failed++;
        $display("FAIL watchdog_fetch cyc%0d got=%b exp=%b", i, outv, s_f[i]);
      end
      if (i < 5) tick();
    end
    mem_ready = 1'b1;
    $display("[TB] watchdog fetch done");
  endtask

  task automatic test_reset_mid();
    logic [17:0] seq [3] = '{E_F_RDY, E_DEC, E_EX_ADD};
    op = 3'b000; funct = 4'b0001; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (outv !== seq[i]) begin
        tests_failed++;
        $display("FAIL reset_mid_pre cyc%0d got=%b exp=%b", i, outv, seq[i]);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (outv !== E_ZERO) begin
      tests_failed++;
      $display("FAIL reset_mid_aluwb got=%b exp=%b", outv, E_ZERO);
    end
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (outv !== E_F_RDY) begin
      tests_failed++;
      $display("FAIL reset_mid_fetch got=%b exp=%b", outv, E_F_RDY);
    end
    tick(); #1;
    tests_run++;
    if (outv !== E_DEC) begin
      tests_failed++;
      $display("FAIL reset_mid_decode got=%b exp=%b", outv, E_DEC);
    end
    $display("[TB] reset mid-instruction done");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi_jump();
    test_lw_wait();
    test_sw();
    test_beq();
    test_illegal();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
